// File: rtl/svm_axis_master_pkg.sv
// svm_axis_pkg: shared state encoding, default parameters and FIFO entry layout for the AXIS master
package svm_axis_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_TDATA_W   = 32;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_ADDR_STEP = 4;
    localparam int DEF_LEN_W     = 16;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [DEF_TDATA_W-1:0] data;
        logic                   last;
    } fifo_entry_t;

endpackage

// File: rtl/svm_axis_master_if.sv
// svm_axis_master_if: control, BRAM and AXI-Stream signals of the stream transmitter
interface svm_axis_master_if import svm_axis_pkg::*; #(
    parameter int WIDTH                = DEF_WIDTH,
    parameter int C_M_AXIS_TDATA_WIDTH = DEF_TDATA_W,
    parameter int MEM_ADDR_WIDTH       = DEF_ADDR_W,
    parameter int LEN_WIDTH            = DEF_LEN_W
);
    logic                                start;
    logic [MEM_ADDR_WIDTH-1:0]           base_addr;
    logic [LEN_WIDTH-1:0]                length;
    logic                                busy;
    logic                                done;
    logic [MEM_ADDR_WIDTH-1:0]           mem_address;
    logic                                mem_en;
    logic [3:0]                          mem_we;
    logic [WIDTH-1:0]                    mem_rdata;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata;
    logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tstrb;
    logic                                m_axis_tvalid;
    logic                                m_axis_tready;
    logic                                m_axis_tlast;

    modport master (
        input  start, base_addr, length, mem_rdata, m_axis_tready,
        output busy, done, mem_address, mem_en, mem_we,
               m_axis_tdata, m_axis_tstrb, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output start, base_addr, length, mem_rdata, m_axis_tready,
        input  busy, done, mem_address, mem_en, mem_we,
               m_axis_tdata, m_axis_tstrb, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/svm_axis_master_axis_skid_fifo.sv
// axis_skid_fifo: 2-entry register FIFO whose head is presented straight from storage registers
module axis_skid_fifo import svm_axis_pkg::*; #(
    parameter int DW = DEF_TDATA_W + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_dout,
    output logic          o_valid,
    output logic [1:0]    o_count
);
    logic [DW-1:0] r_mem [2];
    logic          r_wr;
    logic          r_rd;
    logic [1:0]    r_cnt;
    logic          w_pop;

    assign w_pop   = i_pop && (r_cnt != 2'd0);
    assign o_dout  = r_mem[r_rd];
    assign o_valid = (r_cnt != 2'd0);
    assign o_count = r_cnt;

    // storage, pointers and occupancy; push and pop may coincide, including when full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= ~r_wr;
            end
            if (w_pop) r_rd <= ~r_rd;
            r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/svm_axis_master.sv
// svm_axis_master: reads a block of BRAM samples and streams them sign-extended over AXI-Stream
module svm_axis_master import svm_axis_pkg::*; #(
    parameter int WIDTH                = DEF_WIDTH,
    parameter int C_M_AXIS_TDATA_WIDTH = DEF_TDATA_W,
    parameter int MEM_ADDR_WIDTH       = DEF_ADDR_W,
    parameter int ADDR_STEP            = DEF_ADDR_STEP,
    parameter int LEN_WIDTH            = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    svm_axis_master_if.master  bus
);
    localparam int TW = C_M_AXIS_TDATA_WIDTH;

    state_t                    r_state;
    state_t                    w_next;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]      r_len;
    logic [LEN_WIDTH-1:0]      r_rd_cnt;
    logic                      r_inflight;
    logic                      r_inflight_last;
    logic                      w_issue;
    logic                      w_last_rd;
    logic                      w_pop;
    logic                      w_valid;
    logic [1:0]                w_count;
    logic [TW:0]               w_head;
    logic [TW:0]               w_din;

    assign w_pop     = w_valid && bus.m_axis_tready;
    assign w_last_rd = (r_rd_cnt == r_len - LEN_WIDTH'(1));
    // a read is only issued if its data is guaranteed a FIFO slot once it returns
    assign w_issue   = (r_state == RUN) &&
                       (({1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2);
    assign w_din     = {r_inflight_last, TW'($signed(bus.mem_rdata))};

    assign bus.mem_address   = r_addr;
    assign bus.mem_we        = 4'b0000;
    assign bus.m_axis_tstrb  = '1;
    assign bus.m_axis_tdata  = w_head[TW-1:0];
    assign bus.m_axis_tvalid = w_valid;
    assign bus.m_axis_tlast  = w_valid && w_head[TW];

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // next-state: zero-length commands skip straight to DONE
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = bus.start ? ((bus.length != '0) ? RUN : DONE) : IDLE;
            RUN:     w_next = (w_issue && w_last_rd) ? DRAIN : RUN;
            DRAIN:   w_next = (w_pop && w_head[TW]) ? DONE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    // outputs: busy covers the accepting start cycle and drops when done pulses
    always_comb begin
        bus.busy   = (r_state == RUN) || (r_state == DRAIN) || ((r_state == IDLE) && bus.start);
        bus.done   = (r_state == DONE);
        bus.mem_en = w_issue;
    end

    // command capture, address/read counters and the one-cycle read return tracker
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr          <= '0;
            r_len           <= '0;
            r_rd_cnt        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if ((r_state == IDLE) && bus.start) begin
                r_addr   <= bus.base_addr;
                r_len    <= bus.length;
                r_rd_cnt <= '0;
            end else if (w_issue) begin
                r_addr   <= r_addr + MEM_ADDR_WIDTH'(ADDR_STEP);
                r_rd_cnt <= r_rd_cnt + LEN_WIDTH'(1);
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_last_rd;
        end
    end

    axis_skid_fifo #(.DW(TW + 1)) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (r_inflight),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_valid (w_valid),
        .o_count (w_count)
    );
endmodule

// File: tb/tb_svm_axis_master.sv
// tb_svm_axis_master: directed and randomized commands checked against a queue-based stream model
module tb_svm_axis_master;
    import svm_axis_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    svm_axis_master_if bus ();

    svm_axis_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad = 0;
    logic [15:0] bram [logic [31:0]];
    logic [31:0] addr_q[$];
    fifo_entry_t exp_q[$];
    logic [15:0] vals[$];
    int          mode = 0;
    bit          mon_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    int          issued = 0;
    int          popped = 0;
    int          hs_cnt = 0;
    fifo_entry_t e_mon;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk)
        if (bus.mem_en)
            bus.mem_rdata <= bram.exists(bus.mem_address) ? bram[bus.mem_address] : 16'hDEAD;

    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_prev) begin
                chk("hold_valid", bus.m_axis_tvalid, 1);
                chk("hold_data", bus.m_axis_tdata, prev_data);
                chk("hold_last", bus.m_axis_tlast, prev_last);
            end
            chk("outstanding_le2", (issued - popped) <= 2, 1);
            if (bus.mem_en) begin
                chk("read_expected", addr_q.size() > 0, 1);
                if (addr_q.size() > 0) chk("mem_address", bus.mem_address, addr_q.pop_front());
                issued++;
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                chk("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e_mon = exp_q.pop_front();
                    chk("tdata", bus.m_axis_tdata, e_mon.data);
                    chk("tlast", bus.m_axis_tlast, e_mon.last);
                end
                popped++;
                hs_cnt++;
            end
            stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
            prev_data  = bus.m_axis_tdata;
            prev_last  = bus.m_axis_tlast;
        end
    end

    task automatic drive_ready(input int i);
        bus.m_axis_tready = (mode == 0) ? 1'b1 :
                            (mode == 1) ? ((i % 4 == 0) || (i % 4 == 3)) :
                            1'($urandom_range(0, 1));
    endtask

    task automatic prep(input logic [31:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            logic [31:0] a;
            logic [15:0] d;
            fifo_entry_t e;
            a = base + 32'(k) * 32'd4;
            d = (k < vals.size()) ? vals[k] : 16'($urandom);
            bram[a] = d;
            addr_q.push_back(a);
            e.data = (d >= 16'h8000) ? (32'(d) - 32'h0001_0000) : 32'(d);
            e.last = (k == len - 1);
            exp_q.push_back(e);
        end
        vals.delete();
    endtask

    task automatic run_cmd(input logic [31:0] base, input int len, input bit restart);
        int it = 0;
        int busy_n = 0;
        int firsti = -1;
        int lasti = -1;
        bit got = 1'b0;
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.length    = 16'(len);
        while (!got && it < 3000) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (firsti < 0) firsti = it;
                if (bus.m_axis_tlast) lasti = it;
            end
            if (bus.done) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                it++;
                bus.start     = restart && (it == 2);
                bus.base_addr = $urandom;
                bus.length    = 16'($urandom_range(1, 9));
                drive_ready(it);
            end
        end
        chk("done_seen", got, 1);
        chk("busy_span", busy_n, it);
        if (len != 0) chk("done_after_tlast", it, lasti + 1);
        else          chk("zero_len_done_cycle", it, 1);
        if (mode == 0 && len != 0) chk("sustained_rate", lasti - firsti, len - 1);
        chk("beats_left", exp_q.size(), 0);
        chk("reads_left", addr_q.size(), 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        drive_ready(it + 1);
        @(negedge clk);
        chk("done_pulse_width", bus.done, 0);
        chk("busy_after_done", bus.busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bus.start         = 1'b0;
        bus.base_addr     = '0;
        bus.length        = '0;
        bus.m_axis_tready = 1'b1;
        bus.mem_rdata     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_address", bus.mem_address, 0);
        chk("rst_tvalid", bus.m_axis_tvalid, 0);
        chk("rst_tlast", bus.m_axis_tlast, 0);
        chk("rst_tdata", bus.m_axis_tdata, 0);
        chk("mem_we", bus.mem_we, 0);
        chk("tstrb", bus.m_axis_tstrb, 4'hF);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        mode = 0;
        vals = '{16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        prep(32'h100, 4);
        run_cmd(32'h100, 4, 1'b0);

        run_cmd(32'h200, 0, 1'b0);

        mode = 1;
        prep(32'h400, 8);
        run_cmd(32'h400, 8, 1'b0);

        mode = 2;
        prep(32'hFFFF_FFF8, 4);
        run_cmd(32'hFFFF_FFF8, 4, 1'b0);

        mode = 0;
        prep(32'h800, 4);
        run_cmd(32'h800, 4, 1'b1);
        repeat (4) @(negedge clk);
        chk("ignored_start_idle", bus.m_axis_tvalid || bus.mem_en || bus.busy, 0);
        @(posedge clk);
        #1;

        hs_cnt = 0;
        prep(32'hA00, 6);
        bus.start     = 1'b1;
        bus.base_addr = 32'hA00;
        bus.length    = 16'd6;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n++;
        end while (hs_cnt < 2 && n < 50);
        chk("reset_wait", hs_cnt >= 2, 1);
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        chk("abort_tvalid", bus.m_axis_tvalid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_mem_en", bus.mem_en, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", bus.done, 0);
        end
        addr_q.delete();
        exp_q.delete();
        issued     = 0;
        popped     = 0;
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        prep(32'hB00, 2);
        run_cmd(32'hB00, 2, 1'b0);

        for (int r = 0; r < 4; r++) begin
            logic [31:0] b;
            int          l;
            mode = $urandom_range(0, 2);
            b    = $urandom & 32'hFFFF_FFFC;
            l    = $urandom_range(1, 12);
            prep(b, l);
            run_cmd(b, l, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/svm_axis_master.md
Name: svm_axis_master

Overview:
AXI-Stream transmitter that drives the SVM core's slave stream input (s_axis_*). On a start command it reads a block of WIDTH-bit samples from a BRAM port and emits one sign-extended 32-bit beat per sample, with tlast on the final beat. It sits between the sample/support-vector BRAM and the core's stream port, and is the testbench/system-side source for that port. Control comes from a local start/length/base_addr port that a register block drives.

Parameters:
WIDTH, 16, BRAM sample width; sign-extended to stream width
C_M_AXIS_TDATA_WIDTH, 32, stream data width (must be >= WIDTH)
MEM_ADDR_WIDTH, 32, BRAM byte address width
ADDR_STEP, 4, byte increment between consecutive samples
LEN_WIDTH, 16, width of beat count

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  asynchronous active-low reset
start  in  1  pulse; sampled only in IDLE
base_addr  in  MEM_ADDR_WIDTH  first sample byte address, captured with start
length  in  LEN_WIDTH  number of beats, captured with start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of transfer
mem_address  out  MEM_ADDR_WIDTH  BRAM address
mem_en  out  1  BRAM read enable
mem_we  out  4  BRAM write enable, constant 0
mem_rdata  in  WIDTH  BRAM read data, valid 1 cycle after mem_en
m_axis_tdata  out  C_M_AXIS_TDATA_WIDTH  sign-extended sample
m_axis_tstrb  out  C_M_AXIS_TDATA_WIDTH/8  constant all ones
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  sink ready
m_axis_tlast  out  1  final beat of block

Behaviour:
- Reset (rst=0, async): state IDLE; busy=0, done=0, mem_en=0, mem_address=0, tvalid=0, tlast=0, tdata=0, FIFO empty, counters 0. Reset mid-transfer aborts the transfer. No done pulse. tvalid drops immediately.
- FSM IDLE -> RUN when start=1 and length!=0. IDLE -> DONE when start=1 and length=0: no beats, no BRAM reads. RUN -> DRAIN after the last read is issued. DRAIN -> DONE when the final beat handshakes (tvalid&tready&tlast). DONE -> IDLE after 1 cycle, with done=1 in that cycle.
- start while busy is ignored. base_addr and length are don't-care outside the start cycle.
- Read issue: in RUN, mem_en=1 when (FIFO occupancy + reads in flight) < 2. mem_address = base_addr + k*ADDR_STEP, k = 0..length-1. Address wraps modulo 2^MEM_ADDR_WIDTH.
- Read latency 1: mem_rdata is captured into a 2-entry FIFO the cycle after mem_en. The FIFO head drives tdata/tlast/tvalid directly from registers.
- Timing: start sampled at edge 0 -> mem_en high in cycle 1 -> data in FIFO at edge 2 -> tvalid high in cycle 2 at the latest. With tready held 1, one beat per cycle sustained.
- AXIS rules:
  - Once tvalid=1, tdata/tlast hold stable until the handshake.
  - tvalid is never withdrawn without a handshake, except on reset.
  - tvalid does not depend combinationally on tready.
- tdata = sign-extension of the WIDTH-bit sample to C_M_AXIS_TDATA_WIDTH.
- tlast=1 only on beat index length-1. A FIFO entry carries its own last flag.
- Simultaneous FIFO push and pop when full is allowed: occupancy stays 2.
- Beat counter and read counter are LEN_WIDTH bits. length=2^LEN_WIDTH-1 is supported without overflow.
- done is asserted exactly 1 cycle after the tlast handshake. busy falls in the same cycle that done is high.

Decomposition:
- Package svm_axis_pkg: state enum (IDLE, RUN, DRAIN, DONE), default parameter constants, and a fifo_entry struct {data, last}.
- Sub-module axis_skid_fifo: 2-entry register FIFO with push/pop/occupancy and the same async active-low reset.
- Top holds the FSM, address/read/beat counters, and the sign-extension.

Test Plan:
- base_addr=0x100, length=4, BRAM[0x100..0x10C]=0x0001,0x7FFF,0x8000,0xFFFF, tready=1 -> beats 0x00000001, 0x00007FFF, 0xFFFF8000, 0xFFFFFFFF in 4 consecutive cycles; tlast only on 4th; done 1 cycle later.
- length=0 with start -> no mem_en, no tvalid, done pulse at cycle 1, busy high exactly 1 cycle.
- length=8, tready toggling 1,0,0,1 repeating -> all 8 beats in order; tdata stable while stalled; never more than 2 reads outstanding plus buffered.
- base_addr=0xFFFFFFF8, length=4 -> mem_address sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Second start during busy with length=4 -> ignored; exactly 4 beats from the first command.
- rst asserted after the 2nd beat of a length=6 transfer -> tvalid/busy/mem_en 0 immediately, no done. A new start with length=2 after release -> 2 clean beats, tlast on 2nd.
